// File: rtl/life_gen_sequencer.sv
// Game of Life generation sequencer: ping-pong W x H grid, one cell evaluated per SCAN cycle.
// Define LIFE_TORUS_EN for a toroidal grid; otherwise out-of-range neighbours read as dead.
module life_gen_sequencer #(
    parameter int W = 16,
    parameter int H = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [$clog2(H)-1:0] load_row,
    input  logic [W-1:0]         load_data,
    input  logic                 start,
    input  logic [15:0]          gens,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          gen_count,
    input  logic [$clog2(H)-1:0] rd_row,
    output logic [W-1:0]         rd_data
);

    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);
    localparam logic [RW-1:0] LAST_ROW = RW'(H - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(W - 1);
    localparam logic [RW:0]   H_LIM    = (RW + 1)'(H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t        state_q;
    logic [W-1:0]  buf0_q [H];
    logic [W-1:0]  buf1_q [H];
    logic          front_sel_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [15:0]   remaining_q;
    logic [15:0]   gen_count_q;
    logic          done_q;
    logic [W-1:0]  rd_data_q;

    logic [W-1:0]  front_row [H];
    logic [W-1:0]  up_row, mid_row, dn_row;
    logic [2:0]    up_bits, mid_bits, dn_bits;
    logic [3:0]    ncount;
    logic          cell_d;

    // {left, centre, right} of column c within one row
    function automatic logic [2:0] pick3(input logic [W-1:0] r, input logic [CW-1:0] c);
        logic left, right;
        left  = 1'b0;
        right = 1'b0;
        if (c != '0) left = r[c - CW'(1)];
`ifdef LIFE_TORUS_EN
        else left = r[W-1];
`endif
        if (c != LAST_COL) right = r[c + CW'(1)];
`ifdef LIFE_TORUS_EN
        else right = r[0];
`endif
        return {left, r[c], right};
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < H; i++) begin
            front_row[i] = front_sel_q ? buf1_q[i] : buf0_q[i];
        end
    end

    always_comb begin
        up_row  = '0;
        dn_row  = '0;
        mid_row = front_row[row_q];
        if (row_q != '0) up_row = front_row[row_q - RW'(1)];
`ifdef LIFE_TORUS_EN
        else up_row = front_row[LAST_ROW];
`endif
        if (row_q != LAST_ROW) dn_row = front_row[row_q + RW'(1)];
`ifdef LIFE_TORUS_EN
        else dn_row = front_row[0];
`endif
        up_bits  = pick3(up_row, col_q);
        mid_bits = pick3(mid_row, col_q);
        dn_bits  = pick3(dn_row, col_q);
        ncount = {3'b0, up_bits[2]}  + {3'b0, up_bits[1]}  + {3'b0, up_bits[0]}
               + {3'b0, mid_bits[2]} + {3'b0, mid_bits[0]}
               + {3'b0, dn_bits[2]}  + {3'b0, dn_bits[1]}  + {3'b0, dn_bits[0]};
        cell_d = (ncount == 4'd3) | (mid_bits[1] & (ncount == 4'd2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int unsigned i = 0; i < H; i++) begin
                buf0_q[i] <= '0;
                buf1_q[i] <= '0;
            end
            front_sel_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            remaining_q <= '0;
            gen_count_q <= '0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            rd_data_q <= ({1'b0, rd_row} < H_LIM) ? front_row[rd_row] : '0;
            case (state_q)
                S_IDLE: begin
                    // Load lands on this edge, so a same-cycle start scans the new row
                    if (load_valid && ({1'b0, load_row} < H_LIM)) begin
                        if (front_sel_q) buf1_q[load_row] <= load_data;
                        else             buf0_q[load_row] <= load_data;
                    end
                    if (start) begin
                        if (gens != '0) begin
                            remaining_q <= gens;
                            row_q       <= '0;
                            col_q       <= '0;
                            state_q     <= S_SCAN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (front_sel_q) buf0_q[row_q][col_q] <= cell_d;
                    else             buf1_q[row_q][col_q] <= cell_d;
                    if (col_q == LAST_COL) begin
                        col_q <= '0;
                        if (row_q == LAST_ROW) begin
                            row_q   <= '0;
                            state_q <= S_COMMIT;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                S_COMMIT: begin
                    front_sel_q <= ~front_sel_q;
                    gen_count_q <= gen_count_q + 16'd1;
                    remaining_q <= remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_SCAN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign gen_count  = gen_count_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer on a 16x16 grid; expectations follow LIFE_TORUS_EN.
module tb_life_gen_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  load_row = '0;
    logic [15:0] load_data = '0;
    logic        start = 1'b0;
    logic [15:0] gens = '0;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic [3:0]  rd_row = '0;
    logic [15:0] rd_data;

    int errors = 0;
    int checks = 0;

    localparam int GEN_CYC = 257;

    life_gen_sequencer #(.W(16), .H(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_row   (load_row),
        .load_data  (load_data),
        .start      (start),
        .gens       (gens),
        .busy       (busy),
        .done       (done),
        .gen_count  (gen_count),
        .rd_row     (rd_row),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][3:0]  lr;
        logic [2:0][15:0] ld;
        logic [15:0]      g;
        logic [2:0][3:0]  er;
        logic [2:0][15:0] ed;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic [3:0] l0, input logic [15:0] d0,
                                input logic [3:0] l1, input logic [15:0] d1,
                                input logic [3:0] l2, input logic [15:0] d2,
                                input logic [15:0] g,
                                input logic [3:0] e0, input logic [15:0] x0,
                                input logic [3:0] e1, input logic [15:0] x1,
                                input logic [3:0] e2, input logic [15:0] x2);
        vec_t v;
        v.lr[0] = l0; v.ld[0] = d0;
        v.lr[1] = l1; v.ld[1] = d1;
        v.lr[2] = l2; v.ld[2] = d2;
        v.g     = g;
        v.er[0] = e0; v.ed[0] = x0;
        v.er[1] = e1; v.ed[1] = x1;
        v.er[2] = e2; v.ed[2] = x2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_one(input logic [3:0] r, input logic [15:0] d);
        @(negedge clk);
        load_valid = 1'b1;
        load_row   = r;
        load_data  = d;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] g);
        @(negedge clk);
        gens  = g;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic read_row(input int r, output logic [15:0] d);
        @(negedge clk);
        rd_row = 4'(r);
        @(posedge clk);
        #1;
        d = rd_data;
    endtask

    initial begin
        int cyc;
        logic [15:0] d;
        logic [15:0] exp;

        vecs[0] = mk(4'd7, 16'h01C0, 4'd7, 16'h01C0, 4'd7, 16'h01C0, 16'd1,
                     4'd6, 16'h0080, 4'd7, 16'h0080, 4'd8, 16'h0080);
        vecs[1] = mk(4'd7, 16'h01C0, 4'd7, 16'h01C0, 4'd7, 16'h01C0, 16'd2,
                     4'd7, 16'h01C0, 4'd7, 16'h01C0, 4'd7, 16'h01C0);
`ifdef LIFE_TORUS_EN
        vecs[2] = mk(4'd5, 16'h8003, 4'd5, 16'h8003, 4'd5, 16'h8003, 16'd1,
                     4'd4, 16'h0001, 4'd5, 16'h0001, 4'd6, 16'h0001);
        vecs[6] = mk(4'd0, 16'h8000, 4'd1, 16'h8000, 4'd2, 16'h8000, 16'd1,
                     4'd1, 16'hC001, 4'd1, 16'hC001, 4'd1, 16'hC001);
`else
        vecs[2] = mk(4'd5, 16'h8003, 4'd5, 16'h8003, 4'd5, 16'h8003, 16'd1,
                     4'd0, 16'h0000, 4'd0, 16'h0000, 4'd0, 16'h0000);
        vecs[6] = mk(4'd0, 16'h8000, 4'd1, 16'h8000, 4'd2, 16'h8000, 16'd1,
                     4'd1, 16'hC000, 4'd1, 16'hC000, 4'd1, 16'hC000);
`endif
        vecs[3] = mk(4'd3, 16'h0018, 4'd4, 16'h0018, 4'd4, 16'h0018, 16'd1,
                     4'd3, 16'h0018, 4'd4, 16'h0018, 4'd4, 16'h0018);
        vecs[4] = mk(4'd0, 16'h0001, 4'd0, 16'h0001, 4'd0, 16'h0001, 16'd1,
                     4'd0, 16'h0000, 4'd0, 16'h0000, 4'd0, 16'h0000);
        vecs[5] = mk(4'd0, 16'h0003, 4'd1, 16'h0003, 4'd1, 16'h0003, 16'd2,
                     4'd0, 16'h0003, 4'd1, 16'h0003, 4'd1, 16'h0003);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst load_ready", 32'(load_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst gen_count", 32'(gen_count), 32'd0);
        chk("rst rd_data", 32'(rd_data), 32'd0);

        // Load write appears on rd_data two edges after the load edge
        @(negedge clk);
        rd_row     = 4'd9;
        load_row   = 4'd9;
        load_data  = 16'hA5A5;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        chk("load lat1", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        chk("load lat2", 32'(rd_data), 32'hA5A5);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int j = 0; j < 3; j++) load_one(vecs[v].lr[j], vecs[v].ld[j]);
            start_run(vecs[v].g);
            chk($sformatf("v%0d busy", v), 32'(busy), 32'd1);
            chk($sformatf("v%0d load_ready", v), 32'(load_ready), 32'd0);
            wait_done(cyc);
            chk($sformatf("v%0d done cycle", v), 32'(cyc), 32'(vecs[v].g) * GEN_CYC);
            chk($sformatf("v%0d busy at done", v), 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done pulse", v), 32'(done), 32'd0);
            chk($sformatf("v%0d gen_count", v), 32'(gen_count), 32'(vecs[v].g));
            for (int r = 0; r < 16; r++) begin
                exp = '0;
                for (int j = 0; j < 3; j++) if (int'(vecs[v].er[j]) == r) exp = vecs[v].ed[j];
                read_row(r, d);
                chk($sformatf("v%0d row%0d", v, r), 32'(d), 32'(exp));
            end
        end

        // Block run with start/load attempts while busy
        do_reset();
        load_one(4'd3, 16'h0018);
        load_one(4'd4, 16'h0018);
        start_run(16'd3);
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        start      = 1'b1;
        gens       = 16'd5;
        load_valid = 1'b1;
        load_row   = 4'd0;
        load_data  = 16'hFFFF;
        chk("busy load_ready", 32'(load_ready), 32'd0);
        chk("busy busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        start      = 1'b0;
        load_valid = 1'b0;
        wait_done(cyc);
        chk("block done cycle", 32'(cyc + 21), 32'(3 * GEN_CYC));
        chk("block gen_count", 32'(gen_count), 32'd3);
        read_row(0, d);
        chk("block row0", 32'(d), 32'd0);
        read_row(3, d);
        chk("block row3", 32'(d), 32'h0018);
        read_row(4, d);
        chk("block row4", 32'(d), 32'h0018);
        read_row(5, d);
        chk("block row5", 32'(d), 32'd0);

        // gens=0: single done pulse, nothing else changes
        start_run(16'd0);
        chk("g0 done", 32'(done), 32'd1);
        chk("g0 busy", 32'(busy), 32'd0);
        chk("g0 load_ready", 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("g0 done low", 32'(done), 32'd0);
        chk("g0 gen_count", 32'(gen_count), 32'd3);
        read_row(3, d);
        chk("g0 row3", 32'(d), 32'h0018);

        // Same-cycle load and start: scan sees the loaded row
        do_reset();
        @(negedge clk);
        load_valid = 1'b1;
        load_row   = 4'd7;
        load_data  = 16'h01C0;
        start      = 1'b1;
        gens       = 16'd1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        start      = 1'b0;
        wait_done(cyc);
        chk("same done cycle", 32'(cyc), 32'(GEN_CYC));
        for (int r = 6; r < 9; r++) begin
            read_row(r, d);
            chk($sformatf("same row%0d", r), 32'(d), 32'h0080);
        end

        // Reset in the middle of a glider run
        do_reset();
        load_one(4'd1, 16'h0004);
        load_one(4'd2, 16'h0008);
        load_one(4'd3, 16'h000E);
        start_run(16'd4);
        repeat (600) @(posedge clk);
        #1;
        chk("glider gen_count pre", 32'(gen_count), 32'd2);
        chk("glider busy pre", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        chk("mid rst gen_count", 32'(gen_count), 32'd0);
        chk("mid rst load_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 16; r++) begin
            read_row(r, d);
            chk($sformatf("post rst row%0d", r), 32'(d), 32'd0);
        end
        chk("post rst gen_count", 32'(gen_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/life_gen_sequencer.md
# life_gen_sequencer

Generation sequencer for the Game of Life engine. Holds a W×H cell grid in ping-pong buffers and accepts an initial pattern row by row. On start it runs a requested number of generations. Each generation scans every cell once: it counts the 8 neighbours of each cell and applies the birth/survival rule. It sits between the host-side pattern loader/display reader and the neighbour-evaluation logic, and owns all sequencing of that logic.

## Interface
- W, 16: grid width in cells (≥3)
- H, 16: grid height in rows (≥3)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- load_valid  in  1  row write request
- load_ready  out  1  high only in IDLE
- load_row  in  $clog2(H)  row index to write
- load_data  in  W  row contents, bit c = column c (1 = alive)
- start  in  1  run request, sampled in IDLE only
- gens  in  16  generations to run, sampled with start
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- gen_count  out  16  generations completed since reset, wraps 65535→0
- rd_row  in  $clog2(H)  display read row
- rd_data  out  W  registered front-buffer row, 1-cycle latency

## Operation
- Reset values:
  - state IDLE; both buffers all 0; front pointer buffer 0.
  - load_ready=1, busy=0, done=0, gen_count=0, rd_data=0.
- States: IDLE → SCAN → COMMIT → (SCAN | IDLE).
- IDLE:
  - load_valid && load_ready writes load_data into front[load_row].
  - load_row ≥ H: write dropped.
  - start with gens≠0 latches remaining=gens, clears cell index, enters SCAN.
  - start with gens=0: stays IDLE, pulses done next cycle, grid unchanged.
- Same-cycle load and start: the write lands first, so the scan sees the loaded row.
- SCAN:
  - One cell per cycle, raster order: row 0 col 0 … row H-1 col W-1.
  - n = count of 8 neighbours in the front buffer, range 0..8, 4-bit.
  - back[r][c] = (n==3) | (front[r][c] & n==2).
  - Front buffer is never written during SCAN.
  - After cell (H-1,W-1), go to COMMIT.
- COMMIT:
  - Swap the front pointer; gen_count+1; remaining−1.
  - remaining reaches 0: IDLE, with done=1 for one cycle. Otherwise back to SCAN at cell 0.
- start while busy: ignored, gens not re-sampled. load_ready=0 whenever busy, so load_valid is ignored.
- rd_data: front[rd_row] registered every cycle, valid in any state. rd_row ≥ H returns 0.
- rst mid-run: immediate return to reset values. Both buffers cleared; partial generation discarded.

## Timing
- start sampled at edge k → busy=1 from cycle k+1.
- Each generation: W·H SCAN cycles + 1 COMMIT cycle.
- For gens=N: done=1 and busy=0 in cycle k+1+N·(W·H+1). gen_count already incremented at that point.
- 16×16 grid: 257 cycles per generation.
- Read reflects a new generation from the cycle after COMMIT, plus the 1-cycle rd_data latency.
- load write visible on rd_data two cycles after the load edge, when rd_row matches.

## Configuration
- LIFE_TORUS_EN defined: neighbour coordinates wrap. Row −1→H−1, H→0, column −1→W−1, W→0 (toroidal grid).
- Not defined: out-of-range neighbours read as dead (bounded grid). Wrap logic is not built.

## Test plan
- Blinker, 16×16: load row 7 = cols 6..8, start gens=1. Response: done at k+258; row 6/7/8 each = col 7 only; gen_count=1.
- Same blinker, gens=2. Response: original pattern restored; done at k+515; gen_count=2.
- Wrap: row 5 = cols 15,0,1, gens=1.
  - With LIFE_TORUS_EN: rows 4,5,6 = col 0 only.
  - Without: all rows 0.
- 2×2 block at (3,3), gens=3. During the run: pulse start and load_valid with row 0 = all ones. Response: both ignored; load_ready=0 while busy; block unchanged; gen_count=3.
- gens=0 start: done=1 next cycle only, busy stays 0, grid and gen_count unchanged.
- Assert rst mid-SCAN of a glider run. Response: busy=0, done=0, gen_count=0 immediately; rd_data=0 for every row after release.
